// File: rtl/student_fetch.sv
// Instruction fetch front end: credit-limited ROM request issue,
// in-order response capture into a small FIFO, and redirect flushing.
module student_fetch #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_gnt,
    input  logic              rom_rvalid,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_resp_addr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_live;
    logic [CW-1:0]     r_stale;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pc [DEPTH];

    logic [CW-1:0] w_used;
    logic          w_grant;
    logic          w_drop;
    logic          w_keep;
    logic          w_pop;

    assign w_used  = r_count + r_live + r_stale;
    assign rom_req = reset & ~redirect & (w_used < CW'(DEPTH));
    assign rom_addr = r_fetch_addr;
    assign w_grant = rom_req & rom_gnt;

    // Stale responses are always consumed first; they precede live ones.
    assign w_drop = rom_rvalid & (r_stale != '0);
    assign w_keep = rom_rvalid & (r_stale == '0) & (r_live != '0);
    assign w_pop  = instr_valid & instr_ready;

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_data[r_rptr] : '0;
    assign instr_pc    = instr_valid ? r_pc[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_addr <= RESET_ADDR;
            r_resp_addr  <= RESET_ADDR;
            r_count      <= '0;
            r_live       <= '0;
            r_stale      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else if (redirect) begin
            r_fetch_addr <= redirect_addr;
            r_resp_addr  <= redirect_addr;
            r_count      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_live       <= '0;
            // Everything in flight becomes stale; a response this cycle is dropped.
            r_stale      <= r_stale + r_live - CW'(w_drop | w_keep);
        end else begin
            if (w_grant) begin
                r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
            end
            r_live <= r_live + CW'(w_grant) - CW'(w_keep);
            if (w_drop) begin
                r_stale <= r_stale - CW'(1);
            end
            if (w_keep) begin
                r_wptr      <= r_wptr + PW'(1);
                r_resp_addr <= r_resp_addr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_keep) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !redirect && w_keep) begin
            r_data[r_wptr] <= rom_rdata;
            r_pc[r_wptr]   <= r_resp_addr;
        end
    end

endmodule
